dual_slope_ctrl: RTL and testbench
==================================

DUAL_SLOPE_CTRL -- requirements
Module: dual_slope_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 10: counter and result width.
REQ-002 The block SHALL have parameter T_AZ, default 16: auto-zero phase length in cycles, 1 to 2^CNT_W-1.
REQ-003 The block SHALL have parameter T_INT, default 1000: input integration length in cycles, 1 to 2^CNT_W-1.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port iniciar, input, 1 bit: start request, sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1 bit: cancels a conversion in progress.
REQ-008 The block SHALL have port Vint_z, input, 1 bit: integrator zero-crossing flag, synchronous to clk.
REQ-009 The block SHALL have port Vint_pos, input, 1 bit: integrator output polarity, 1 = positive, synchronous to clk.
REQ-010 The block SHALL have port ch, output, 4 bits, one-hot switch select: [0] Vm, [1] +ref, [2] zero, [3] -ref.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a completed conversion.
REQ-013 The block SHALL have port overflow, output, 1 bit: last conversion hit full scale.
REQ-014 The block SHALL have port sign, output, 1 bit: last conversion had negative input.
REQ-015 The block SHALL have port result, output, CNT_W bits: last de-integration count.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, AUTOZERO, INTEGRATE, DEINTEGRATE, DONE; all outputs are registered.
REQ-017 In IDLE, ch SHALL be 4'b0100; iniciar=1 SHALL move the FSM to AUTOZERO on the next cycle and clear the counter.
REQ-018 AUTOZERO SHALL drive ch=4'b0100 for exactly T_AZ cycles, then enter INTEGRATE with the counter cleared.
REQ-019 INTEGRATE SHALL drive ch=4'b0001 for exactly T_INT cycles; on its last cycle the block SHALL latch sign=~Vint_pos when DUAL_SLOPE_POLARITY_EN is defined, and the FSM then enters DEINTEGRATE with the counter at 0.
REQ-020 DEINTEGRATE SHALL drive ch=4'b0010 when sign=0 and ch=4'b1000 when sign=1; the counter increments by 1 each cycle, starting at 0 in the first cycle.
REQ-021 In DEINTEGRATE, Vint_z=1 SHALL cause result to load the current count, overflow to load 0, and the FSM to enter DONE.
REQ-022 In DEINTEGRATE, count=2^CNT_W-1 with Vint_z=0 SHALL cause result to load all-ones, overflow to load 1, and the FSM to enter DONE; the counter never wraps.
REQ-023 DONE SHALL last one cycle with done=1 and ch=4'b0100, then return to IDLE.
REQ-024 result, overflow and sign SHALL hold their values until the next DONE entry; sign SHALL be updated only at the REQ-019 latch point.
REQ-025 iniciar SHALL be ignored when busy=1.
REQ-026 abort=1 in AUTOZERO, INTEGRATE or DEINTEGRATE SHALL force IDLE on the next cycle with no done pulse and no change to result, overflow or sign; abort SHALL be ignored in IDLE and DONE.
REQ-027 ch SHALL be one-hot in every cycle.

Reset
REQ-028 reset=1 SHALL take priority over all other inputs and force on the next edge: state IDLE, counter 0, ch=4'b0100, busy=0, done=0, overflow=0, sign=0, result=0.
REQ-029 Reset asserted mid-conversion SHALL discard the conversion silently, with no done pulse.

Configuration
REQ-030 With macro DUAL_SLOPE_POLARITY_EN defined, the block SHALL latch sign per REQ-019 and use -ref (ch[3]) for negative inputs.
REQ-031 With DUAL_SLOPE_POLARITY_EN undefined, sign SHALL be constant 0, ch[3] SHALL be constant 0, and Vint_pos SHALL be unused.

Verification (CNT_W=10, T_AZ=4, T_INT=100)
REQ-032 Scenario 1: reset, then iniciar for 1 cycle, with Vint_z raised on the 37th DEINTEGRATE cycle -> done high exactly 141 cycles after the edge sampling iniciar, result=36, overflow=0, busy low the following cycle.
REQ-033 Scenario 2: Vint_z held 0 throughout -> after 1024 DEINTEGRATE cycles, result=1023, overflow=1, done pulse for 1 cycle.
REQ-034 Scenario 3: Vint_z=1 already in the first DEINTEGRATE cycle -> result=0, overflow=0.
REQ-035 Scenario 4: complete one conversion with result=36, then abort at INTEGRATE cycle 50 -> IDLE next cycle, ch=4'b0100, no done pulse, result still 36; iniciar pulsed while busy -> no restart; iniciar and reset together -> stays IDLE.
REQ-036 Scenario 5: with the macro defined, Vint_pos=0 on the last INTEGRATE cycle -> sign=1 and ch=4'b1000 throughout DEINTEGRATE; without the macro, same stimulus -> sign=0, ch=4'b0010.
REQ-037 Scenario 6: reset asserted in DEINTEGRATE -> all REQ-028 values on the next cycle, no done pulse.

Source files
------------

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: auto-zero, fixed-time integrate, timed de-integrate.
// Optional input polarity handling (sign latch, -ref switch) enabled by DUAL_SLOPE_POLARITY_EN.
module dual_slope_ctrl #(
  parameter int CNT_W = 10,
  parameter int T_AZ  = 16,
  parameter int T_INT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             abort,
  input  logic             Vint_z,
  input  logic             Vint_pos,
  output logic [3:0]       ch,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             sign,
  output logic [CNT_W-1:0] result
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    AUTOZERO    = 3'd1,
    INTEGRATE   = 3'd2,
    DEINTEGRATE = 3'd3,
    DONE        = 3'd4
  } state_t;

  localparam logic [3:0] CH_VM   = 4'b0001;
  localparam logic [3:0] CH_PREF = 4'b0010;
  localparam logic [3:0] CH_ZERO = 4'b0100;
  localparam logic [3:0] CH_NREF = 4'b1000;

  localparam logic [CNT_W-1:0] AZ_LAST  = CNT_W'(T_AZ - 1);
  localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(T_INT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sign_latch_s;

`ifdef DUAL_SLOPE_POLARITY_EN
  // Polarity at the end of integration selects the opposing reference.
  always_comb begin
    sign_latch_s = ~Vint_pos;
  end
`else
  logic unused_vint_pos_s;
  assign unused_vint_pos_s = Vint_pos;

  // Without polarity support every input is treated as positive.
  always_comb begin
    sign_latch_s = 1'b0;
  end
`endif

  // Sequencer state, phase counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      ch       <= CH_ZERO;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      sign     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          ch <= CH_ZERO;
          if (iniciar) begin
            state_r <= AUTOZERO;
            cnt_r   <= '0;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        AUTOZERO: begin
          if (abort) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            ch      <= CH_ZERO;
          end else if (cnt_r == AZ_LAST) begin
            state_r <= INTEGRATE;
            cnt_r   <= '0;
            ch      <= CH_VM;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        INTEGRATE: begin
          if (abort) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            ch      <= CH_ZERO;
          end else if (cnt_r == INT_LAST) begin
            state_r <= DEINTEGRATE;
            cnt_r   <= '0;
            sign    <= sign_latch_s;
            ch      <= sign_latch_s ? CH_NREF : CH_PREF;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DEINTEGRATE: begin
          // Zero crossing wins over full scale when both occur together.
          if (abort) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            ch      <= CH_ZERO;
          end else if (Vint_z) begin
            state_r  <= DONE;
            result   <= cnt_r;
            overflow <= 1'b0;
            done     <= 1'b1;
            ch       <= CH_ZERO;
          end else if (cnt_r == CNT_FULL) begin
            state_r  <= DONE;
            result   <= CNT_FULL;
            overflow <= 1'b1;
            done     <= 1'b1;
            ch       <= CH_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          ch      <= CH_ZERO;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy    <= 1'b0;
          ch      <= CH_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed bench for dual_slope_ctrl with CNT_W=10, T_AZ=4, T_INT=100.
module tb_dual_slope_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       abort = 1'b0;
  logic       Vint_z = 1'b0;
  logic       Vint_pos = 1'b1;
  logic [3:0] ch;
  logic       busy, done, overflow, sign;
  logic [9:0] result;

  int vectors = 0;
  int miscompares = 0;

  dual_slope_ctrl #(.CNT_W(10), .T_AZ(4), .T_INT(100)) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .abort(abort),
    .Vint_z(Vint_z), .Vint_pos(Vint_pos), .ch(ch), .busy(busy),
    .done(done), .overflow(overflow), .sign(sign), .result(result)
  );

  always #5 clk = ~clk;

`ifdef DUAL_SLOPE_POLARITY_EN
  localparam logic       NEG_SIGN = 1'b1;
  localparam logic [3:0] NEG_CH   = 4'b1000;
`else
  localparam logic       NEG_SIGN = 1'b0;
  localparam logic [3:0] NEG_CH   = 4'b0010;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one conversion from IDLE. n counts edges after the one sampling iniciar;
  // Vint_z is raised during DEINTEGRATE cycle z_at (0 = never).
  task automatic conv(input int z_at, input logic vpos, output int done_at,
                      output logic [3:0] ch_az, output logic [3:0] ch_int,
                      output logic [3:0] ch_de, output int oh_err);
    done_at = -1; oh_err = 0; ch_az = 4'd0; ch_int = 4'd0; ch_de = 4'd0;
    Vint_pos = vpos;
    iniciar = 1'b1;
    tick;
    iniciar = 1'b0;
    if (!$onehot(ch)) oh_err++;
    for (int n = 1; n <= 1200; n++) begin
      Vint_z = (z_at > 0) && (n - 1 == 103 + z_at);
      tick;
      if (!$onehot(ch)) oh_err++;
      if (n == 1) ch_az = ch;
      if (n == 50) ch_int = ch;
      if (n == 104) ch_de = ch;
      if (done === 1'b1) begin
        done_at = n;
        break;
      end
    end
    Vint_z = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    vectors++;
    if ({ch, busy, done, overflow, sign, result} !== {4'b0100, 4'b0000, 10'd0}) begin
      miscompares++;
      $display("FAIL reset: ch=%b busy=%b done=%b ovf=%b sign=%b result=%0d, want ch=0100 others 0",
               ch, busy, done, overflow, sign, result);
    end
    tick;
    vectors++;
    if (busy !== 1'b0 || ch !== 4'b0100) begin
      miscompares++;
      $display("FAIL idle_hold: busy=%b ch=%b, want 0 0100", busy, ch);
    end
  endtask

  task automatic test_normal;
    int d, oh; logic [3:0] a, i, e;
    conv(37, 1'b1, d, a, i, e, oh);
    vectors++;
    if (d !== 141) begin miscompares++; $display("FAIL normal_latency: got %0d want 141", d); end
    vectors++;
    if (result !== 10'd36 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL normal_result: result=%0d ovf=%b want 36 0", result, overflow);
    end
    vectors++;
    if ({a, i, e} !== {4'b0100, 4'b0001, 4'b0010}) begin
      miscompares++; $display("FAIL normal_ch: az=%b int=%b de=%b want 0100 0001 0010", a, i, e);
    end
    vectors++;
    if (oh !== 0) begin miscompares++; $display("FAIL onehot: %0d bad cycles want 0", oh); end
    tick;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || ch !== 4'b0100) begin
      miscompares++; $display("FAIL normal_after: busy=%b done=%b ch=%b want 0 0 0100", busy, done, ch);
    end
  endtask

  task automatic test_overflow;
    int d, oh; logic [3:0] a, i, e;
    conv(0, 1'b1, d, a, i, e, oh);
    vectors++;
    if (d !== 1128) begin miscompares++; $display("FAIL ovf_latency: got %0d want 1128", d); end
    vectors++;
    if (result !== 10'd1023 || overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_result: result=%0d ovf=%b want 1023 1", result, overflow);
    end
    tick;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL ovf_pulse: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_zero_first;
    int d, oh; logic [3:0] a, i, e;
    conv(1, 1'b1, d, a, i, e, oh);
    vectors++;
    if (d !== 105 || result !== 10'd0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_first: done_at=%0d result=%0d ovf=%b want 105 0 0", d, result, overflow);
    end
    tick;
  endtask

  task automatic test_abort;
    int d, oh, dones; logic [3:0] a, i, e;
    conv(37, 1'b1, d, a, i, e, oh);
    tick;
    vectors++;
    if (result !== 10'd36) begin miscompares++; $display("FAIL abort_setup: result=%0d want 36", result); end
    iniciar = 1'b1; tick; iniciar = 1'b0;   // after E0
    tick; tick;                              // after E2
    iniciar = 1'b1; tick; iniciar = 1'b0;   // busy, must be ignored
    tick;                                    // after E4
    vectors++;
    if (ch !== 4'b0001) begin miscompares++; $display("FAIL busy_iniciar: ch=%b want 0001", ch); end
    repeat (49) tick;                        // after E53: INTEGRATE cycle 50
    abort = 1'b1; tick; abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || ch !== 4'b0100 || done !== 1'b0 || result !== 10'd36 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: busy=%b ch=%b done=%b result=%0d ovf=%b want 0 0100 0 36 0",
               busy, ch, done, result, overflow);
    end
    dones = 0;
    for (int k = 0; k < 5; k++) begin tick; if (done !== 1'b0 || busy !== 1'b0) dones++; end
    vectors++;
    if (dones !== 0) begin miscompares++; $display("FAIL abort_quiet: %0d active cycles want 0", dones); end
    iniciar = 1'b1; reset = 1'b1; tick; iniciar = 1'b0; reset = 1'b0;
    tick;
    vectors++;
    if (busy !== 1'b0 || ch !== 4'b0100 || result !== 10'd0) begin
      miscompares++; $display("FAIL reset_iniciar: busy=%b ch=%b result=%0d want 0 0100 0", busy, ch, result);
    end
  endtask

  task automatic test_polarity;
    int d, oh; logic [3:0] a, i, e;
    conv(5, 1'b0, d, a, i, e, oh);
    vectors++;
    if (sign !== NEG_SIGN || e !== NEG_CH || result !== 10'd4 || d !== 109) begin
      miscompares++;
      $display("FAIL polarity_neg: sign=%b ch=%b result=%0d done_at=%0d want %b %b 4 109",
               sign, e, result, d, NEG_SIGN, NEG_CH);
    end
    tick;
    conv(3, 1'b1, d, a, i, e, oh);
    vectors++;
    if (sign !== 1'b0 || e !== 4'b0010 || result !== 10'd2) begin
      miscompares++; $display("FAIL polarity_pos: sign=%b ch=%b result=%0d want 0 0010 2", sign, e, result);
    end
    tick;
    conv(5, 1'b0, d, a, i, e, oh);
    tick;
  endtask

  task automatic test_reset_mid;
    int act;
    iniciar = 1'b1; tick; iniciar = 1'b0;
    repeat (113) tick;                       // DEINTEGRATE cycle 10
    vectors++;
    if (busy !== 1'b1 || ch !== NEG_CH) begin
      miscompares++; $display("FAIL reset_mid_setup: busy=%b ch=%b want 1 %b", busy, ch, NEG_CH);
    end
    reset = 1'b1; tick; reset = 1'b0;
    vectors++;
    if ({ch, busy, done, overflow, sign, result} !== {4'b0100, 4'b0000, 10'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: ch=%b busy=%b done=%b ovf=%b sign=%b result=%0d, want ch=0100 others 0",
               ch, busy, done, overflow, sign, result);
    end
    act = 0;
    for (int k = 0; k < 4; k++) begin Vint_z = 1'b1; tick; if (done !== 1'b0 || busy !== 1'b0) act++; end
    Vint_z = 1'b0;
    vectors++;
    if (act !== 0) begin miscompares++; $display("FAIL reset_mid_quiet: %0d active cycles want 0", act); end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_overflow;
    test_zero_first;
    test_abort;
    test_polarity;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
